countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- Loadable down-counter: a value is accepted through a valid/ready handshake, counted down to zero while enabled, and a one-cycle expired pulse is signalled at terminal count.
- Optional auto-reload turns it into a periodic tick generator.
- Complements the existing 8-bit up-counter. It serves as the timeout/interval source for control FSMs in the same clock domain.

Parameters:
- WIDTH, 8, bit width of the load value and the count register.

Ports:
- clk  input  1  single system clock; all state updates on posedge clk.
- reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk.
- enable  input  1  count-enable; when 0 in RUN the count holds (pause).
- load_valid  input  1  load request; qualifies load_value.
- load_ready  output  1  block can accept a load (high only in IDLE).
- load_value  input  WIDTH  start count; captured on handshake.
- auto_reload  input  1  sampled in EXPIRE; 1 = restart from last loaded value.
- cancel  input  1  abort a running count.
- count_output  output  WIDTH  current count register, driven directly from the register.
- busy  output  1  state != IDLE.
- expired  output  1  high for exactly the EXPIRE cycle.

Behaviour:
- Reset values:
  - state = IDLE; count = 0; reload_reg = 0.
  - count_output = 0; busy = 0; expired = 0; load_ready = 1.
- States: IDLE, RUN, EXPIRE. All outputs are decoded from registered state/count, so there are no combinational input-to-output paths.
- IDLE:
  - load_ready = 1. Handshake is load_valid && load_ready.
  - On handshake: count <= load_value; reload_reg <= load_value.
  - Next state is RUN, or EXPIRE if load_value == 0.
  - count_output shows load_value on the cycle after the handshake.
  - enable and cancel are ignored in IDLE.
- RUN:
  - cancel=1 (priority over enable): count <= 0, state <= IDLE, no expired pulse.
  - Else if enable=1 and count == 1: count <= 0, state <= EXPIRE.
  - Else if enable=1: count <= count - 1.
  - Else: hold.
  - The count never wraps below 0.
- EXPIRE (exactly one cycle):
  - expired = 1; load_ready = 0.
  - If cancel=1: state <= IDLE; expired is still high this cycle.
  - Else if auto_reload=1 and reload_reg != 0: count <= reload_reg, state <= RUN.
  - Else: state <= IDLE, count stays 0.
- Timing with enable held at 1:
  - Load N (N >= 1): RUN lasts N cycles (count N..1), then 1 EXPIRE cycle.
  - expired is asserted N+1 cycles after the handshake edge.
  - With auto_reload, the expired pulse period is N+1 cycles.
- Pausing: enable=0 extends RUN cycle-for-cycle. EXPIRE is not affected by enable.
- Zero load: go straight to EXPIRE (one expired pulse). With reload_reg == 0, auto_reload is ignored, which prevents an endless EXPIRE loop.
- Maximum load value 2^WIDTH-1 (255 at default) must count fully.
- load_valid while busy is ignored: load_ready=0 and the value is not captured.
- Asynchronous reset asserted mid-RUN or mid-EXPIRE: all outputs reach reset values immediately. expired drops in the same cycle. Counting resumes only after a new load following reset deassertion.

Decomposition:
- Shared package countdown_timer_pkg:
  - state enum typedef (IDLE, RUN, EXPIRE), 2-bit encoding.
  - default WIDTH constant.
- Single module. Structure: one always_ff with asynchronous reset for state/count/reload_reg, plus one always_comb for next-state logic and outputs.
- No sub-module is warranted.

Test Plan:
- Reset, then load 5 with enable=1, auto_reload=0 -> count_output 5,4,3,2,1,0; expired high 6 cycles after the handshake for exactly 1 cycle; busy falls and load_ready rises the following cycle.
- Load 3, auto_reload=1, enable=1 -> expired pulses every 4 cycles; count sequence 3,2,1,0,3,2,1,0...
- Load 4, then drop enable for 3 cycles after the count reaches 2 -> count holds at 2 for 3 cycles; expired is delayed by exactly 3 cycles versus the unpaused run.
- Load 10, assert cancel when count=6 -> next cycle count=0, state IDLE, expired never asserted; load_valid with 7 while busy earlier was not captured.
- Load 0 with auto_reload=1 -> a single expired pulse the cycle after the handshake, then IDLE. Separately, load 255 -> expired after 256 cycles with no wrap.
- Assert reset asynchronously mid-RUN (count=9) and during an EXPIRE cycle -> count_output=0, busy=0, expired=0, load_ready=1 immediately without waiting for a clk edge.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the loadable countdown timer.
// Imported by the timer and by any control FSM that consumes its tick.
package countdown_timer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } timer_state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load, pause, cancel and optional auto-reload.
// Every output is decoded from registered state, so inputs never reach outputs combinationally.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             cancel,
    output logic [WIDTH-1:0] count_output,
    output logic             busy,
    output logic             expired
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    count_d  = load_value;
                    reload_d = load_value;
                    state_d  = (load_value == '0) ? EXPIRE : RUN;
                end
            end

            RUN: begin
                if (cancel) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (enable) begin
                    // Treat a zero count like one so the register can never wrap.
                    if (count_q <= WIDTH'(1)) begin
                        count_d = '0;
                        state_d = EXPIRE;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end

            EXPIRE: begin
                if (cancel) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (auto_reload && (reload_q != '0)) begin
                    count_d = reload_q;
                    state_d = RUN;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign load_ready   = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign expired      = (state_q == EXPIRE);
    assign count_output = count_q;

endmodule
